// File: rtl/pwm_pkg.sv
// Shared types for the PWM channel: FSM states and the double-buffered config payload.
package pwm_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    PWM_IDLE     = 2'd0,
    PWM_RUN_UP   = 2'd1,
    PWM_RUN_DOWN = 2'd2
  } pwm_state_e;

  // Sized by CNT_W_DEF so the AXI register block can share the same layout.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] period;
    logic [CNT_W_DEF-1:0] duty;
    logic                 center;
  } pwm_cfg_t;

endpackage

// File: rtl/pwm_if.sv
// Register-side bundle of one PWM channel: live config in, waveform and status out.
interface pwm_if
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             tick;
  logic             enable;
  logic             center_mode;
  logic             polarity;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] duty;
  logic             update_req;
  logic             update_ack;
  logic             pwm_out;
  logic             period_done;
  logic [CNT_W-1:0] count_out;

  modport master (
    output tick, enable, center_mode, polarity, period, duty, update_req,
    input  update_ack, pwm_out, period_done, count_out
  );

  modport slave (
    input  tick, enable, center_mode, polarity, period, duty, update_req,
    output update_ack, pwm_out, period_done, count_out
  );
endinterface

// File: rtl/pwm_shadow_regs.sv
// Shadow copy of period/duty/mode plus the pending-update flag and its acknowledge pulse.
module pwm_shadow_regs
  import pwm_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_load,
  input  logic     i_clr,
  input  logic     i_req,
  input  pwm_cfg_t i_live,
  output pwm_cfg_t o_cfg,
  output logic     o_pending,
  output logic     o_update_ack
);

  pwm_cfg_t r_cfg;
  logic     r_pending;
  logic     r_ack;

  // A load only acknowledges when an update was actually outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg     <= '0;
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_ack <= i_load & (r_pending | i_req);
      if (i_load) begin
        r_cfg <= i_live;
      end
      if (i_clr || i_load) begin
        r_pending <= 1'b0;
      end else if (i_req) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign o_cfg        = r_cfg;
  assign o_pending    = r_pending;
  assign o_update_ack = r_ack;

endmodule

// File: rtl/pwm_channel.sv
// Per-channel PWM engine: tick-driven period counter, edge/center alignment, glitch-free
// double-buffered period/duty/mode updates at period boundaries.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
)(
  input logic  clk,
  input logic  rst_n,
  pwm_if.slave bus
);

  pwm_state_e       r_state;
  pwm_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_pwm;
  logic             w_pwm_nxt;
  logic             r_done;
  logic             w_boundary;
  logic             w_start;
  logic             w_clr;
  logic             w_upd;
  logic             w_load;
  logic             w_pending;
  logic             w_ack;
  pwm_cfg_t         w_live_cfg;
  pwm_cfg_t         w_cfg;
  logic [CNT_W-1:0] w_ps;
  logic [CNT_W-1:0] w_ds;
  logic             w_center;
  logic [CNT_W-1:0] w_inc;
  logic [CNT_W-1:0] w_dec;

  always_comb begin
    w_live_cfg        = '0;
    w_live_cfg.period = CNT_W_DEF'(bus.period);
    w_live_cfg.duty   = CNT_W_DEF'(bus.duty);
    w_live_cfg.center = bus.center_mode;
  end

  assign w_ps     = CNT_W'(w_cfg.period);
  assign w_ds     = CNT_W'(w_cfg.duty);
  assign w_center = w_cfg.center;
  assign w_inc    = r_count + CNT_W'(1);
  assign w_dec    = r_count - CNT_W'(1);
  assign w_upd    = w_pending | bus.update_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PWM_IDLE;
      r_count <= '0;
      r_pwm   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_pwm   <= w_pwm_nxt;
      r_done  <= w_boundary;
    end
  end

  // Next state, counter, compare; stop has priority over any same-cycle tick.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_pwm_nxt   = bus.polarity;
    w_boundary  = 1'b0;
    w_start     = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      PWM_IDLE: begin
        w_count_nxt = '0;
        if (bus.enable) begin
          w_start     = 1'b1;
          w_state_nxt = PWM_RUN_UP;
        end
      end
      PWM_RUN_UP, PWM_RUN_DOWN: begin
        if (!bus.enable) begin
          w_state_nxt = PWM_IDLE;
          w_count_nxt = '0;
          w_clr       = 1'b1;
        end else begin
          w_pwm_nxt = (r_count < w_ds) ^ bus.polarity;
          if (bus.tick) begin
            if (w_ps == '0) begin
              w_count_nxt = '0;
              w_boundary  = 1'b1;
              w_state_nxt = PWM_RUN_UP;
            end else if (!w_center) begin
              w_state_nxt = PWM_RUN_UP;
              if (r_count == w_ps) begin
                w_count_nxt = '0;
                w_boundary  = 1'b1;
              end else begin
                w_count_nxt = w_inc;
              end
            end else if (r_state == PWM_RUN_UP) begin
              w_count_nxt = w_inc;
              if (w_inc == w_ps) begin
                w_state_nxt = PWM_RUN_DOWN;
              end
            end else begin
              w_count_nxt = w_dec;
              if (w_dec == '0) begin
                w_state_nxt = PWM_RUN_UP;
                w_boundary  = 1'b1;
              end
            end
          end
        end
      end
      default: begin
        w_state_nxt = PWM_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // Every boundary leaves the counter at 0 in RUN_UP, so a mode change restarts cleanly.
  assign w_load = w_start | (w_boundary & w_upd);

  pwm_shadow_regs u_shadow (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load),
    .i_clr        (w_clr),
    .i_req        (bus.update_req),
    .i_live       (w_live_cfg),
    .o_cfg        (w_cfg),
    .o_pending    (w_pending),
    .o_update_ack (w_ack)
  );

  assign bus.update_ack  = w_ack;
  assign bus.pwm_out     = r_pwm;
  assign bus.period_done = r_done;
  assign bus.count_out   = r_count;

endmodule

// File: tb/tb_pwm_channel.sv
// Directed and randomized checks of pwm_channel against a phase-based reference model.
module tb_pwm_channel;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  pwm_if u_if ();

  pwm_channel u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the period as a phase index.
  bit m_run, m_center, m_pend, m_pwm, m_done, m_ack;
  int m_phase, m_ps, m_ds;

  function automatic int m_cnt();
    if (m_center && m_phase > m_ps) return 2 * m_ps - m_phase;
    return m_phase;
  endfunction

  task automatic model_reset();
    m_run = 0; m_center = 0; m_pend = 0; m_pwm = 0; m_done = 0; m_ack = 0;
    m_phase = 0; m_ps = 0; m_ds = 0;
  endtask

  task automatic model_load();
    m_ps     = int'(u_if.period);
    m_ds     = int'(u_if.duty);
    m_center = u_if.center_mode;
  endtask

  task automatic model_clk();
    bit en, tk, req, pol, bnd, upd, pwm_n, ack_n;
    int len;
    en = u_if.enable; tk = u_if.tick; req = u_if.update_req; pol = u_if.polarity;
    bnd = 0; ack_n = 0;
    upd = m_pend || req;
    pwm_n = (m_run && en) ? ((m_cnt() < m_ds) ^ pol) : pol;
    if (!m_run) begin
      if (en) begin
        m_run = 1; m_phase = 0; ack_n = upd; m_pend = 0;
        model_load();
      end else begin
        m_pend = upd;
      end
    end else if (!en) begin
      m_run = 0; m_phase = 0; m_pend = 0;
    end else begin
      if (tk) begin
        if (m_ps == 0) begin
          bnd = 1;
        end else begin
          len = m_center ? 2 * m_ps : m_ps + 1;
          m_phase++;
          if (m_phase == len) begin
            m_phase = 0;
            bnd = 1;
          end
        end
      end
      if (bnd && upd) begin
        model_load(); ack_n = 1; m_pend = 0;
      end else begin
        m_pend = upd;
      end
    end
    m_pwm = pwm_n; m_done = bnd; m_ack = ack_n;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pwm_out", 32'(u_if.pwm_out), 32'(m_pwm));
    chk("count_out", 32'(u_if.count_out), 32'(m_cnt()));
    chk("period_done", 32'(u_if.period_done), 32'(m_done));
    chk("update_ack", 32'(u_if.update_ack), 32'(m_ack));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_clk();
    #1;
    check_all();
  endtask

  task automatic request(input int p, input int d, input bit c);
    u_if.period = 16'(p); u_if.duty = 16'(d); u_if.center_mode = c;
    u_if.update_req = 1'b1;
    cyc();
    u_if.update_req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int k, gap;
    n_chk = 0; n_err = 0;
    model_reset();
    rst_n = 1'b0;
    u_if.tick = 1'b1; u_if.enable = 1'b0; u_if.center_mode = 1'b0; u_if.polarity = 1'b0;
    u_if.period = 16'd4; u_if.duty = 16'd2; u_if.update_req = 1'b0;
    #12;
    chk("rst_pwm", 32'(u_if.pwm_out), 0);
    chk("rst_count", 32'(u_if.count_out), 0);
    chk("rst_done", 32'(u_if.period_done), 0);
    chk("rst_ack", 32'(u_if.update_ack), 0);
    rst_n = 1'b1;
    cyc();

    // Edge mode P=4 D=2: literal waveform 1,1,0,0,0
    u_if.enable = 1'b1;
    cyc();
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("edge_pwm", 32'(u_if.pwm_out), 32'((i % 5) < 2));
      chk("edge_cnt", 32'(u_if.count_out), 32'((i + 1) % 5));
      chk("edge_done", 32'(u_if.period_done), 32'((i % 5) == 4));
    end

    // Center mode P=4 D=2, switched at the next boundary
    request(4, 2, 1'b1);
    run(30);

    // Mid-period duty update
    request(9, 3, 1'b0);
    run(20);
    run(4);
    request(9, 7, 1'b0);
    run(25);

    // Stop at count 5, then restart
    k = 0;
    while (u_if.count_out != 16'd5 && k < 40) begin cyc(); k++; end
    chk("reach_cnt5", 32'(u_if.count_out), 5);
    u_if.enable = 1'b0;
    cyc();
    chk("stop_cnt", 32'(u_if.count_out), 0);
    chk("stop_pwm", 32'(u_if.pwm_out), 32'(u_if.polarity));
    chk("stop_done", 32'(u_if.period_done), 0);
    run(3);
    u_if.enable = 1'b1;
    run(12);

    // Boundary duty/period values with both polarities
    for (int pol = 0; pol < 2; pol++) begin
      u_if.polarity = pol[0];
      request(5, 0, 1'b0); run(14);
      request(5, 6, 1'b0); run(14);
      request(5, 5, 1'b1); run(14);
      request(0, 0, 1'b0); run(6);
      request(0, 1, 1'b1); run(6);
    end
    u_if.polarity = 1'b0;

    // Asynchronous reset mid-run
    request(4, 2, 1'b0);
    run(7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pwm", 32'(u_if.pwm_out), 0);
    chk("arst_count", 32'(u_if.count_out), 0);
    chk("arst_done", 32'(u_if.period_done), 0);
    chk("arst_ack", 32'(u_if.update_ack), 0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    run(3);

    // Tick every third cycle stretches P=4 edge period to 15 cycles
    k = 0; gap = 0;
    while (u_if.period_done !== 1'b1 && k < 60) begin
      u_if.tick = (k % 3 == 0); cyc(); k++;
    end
    while (gap < 60) begin
      u_if.tick = (k % 3 == 0); cyc(); k++; gap++;
      if (u_if.period_done === 1'b1) break;
    end
    chk("tick3_period", 32'(gap), 15);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      u_if.tick = ($urandom_range(0, 2) != 0);
      u_if.update_req = 1'b0;
      if ($urandom_range(0, 24) == 0) begin
        u_if.period = 16'($urandom_range(0, 7));
        u_if.duty = 16'($urandom_range(0, 9));
        u_if.center_mode = 1'($urandom_range(0, 1));
        u_if.update_req = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) u_if.polarity = ~u_if.polarity;
      if (u_if.enable && $urandom_range(0, 79) == 0) u_if.enable = 1'b0;
      else if (!u_if.enable && $urandom_range(0, 5) == 0) u_if.enable = 1'b1;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
